store_unit_ctrl: RTL and testbench
==================================

// Module: store_unit_ctrl
// PURPOSE
//  Store-path sequencer for the MEM stage. Accepts one store per request from EX, aligns
//  write data onto byte lanes (BusB shifted left by 8*addr[1:0]), builds byte enables,
//  checks alignment and opcode, and drives a req/ack write to data memory. It is a
//  one-entry posted buffer and stalls EX only while a previous store is still pending.
// PARAMETERS
//  MAX_WAIT  15  cycles in REQ without mem_ack before a timeout error; 0 disables timeout
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  st_valid   in   1   store request from EX this cycle
//  st_op      in   2   00 SB, 01 SH, 10 SW, 11 illegal
//  st_addr    in   32  byte address of store
//  st_data    in   32  register data (BusB), value in low bytes
//  flush      in   1   squash st_valid this cycle (branch/exception)
//  st_stall   out  1   EX must hold its store; request not accepted this cycle
//  st_done    out  1   one-cycle pulse: posted store completed
//  st_err     out  1   one-cycle pulse: store rejected or timed out
//  err_code   out  2   01 misaligned, 10 timeout, 11 illegal op; valid with st_err
//  err_addr   out  32  st_addr of the failing store; valid with st_err
//  mem_req    out  1   write request to data memory, held until ack/timeout
//  mem_addr   out  32  word address {addr[31:2],2'b00}
//  mem_wdata  out  32  lane-aligned write data
//  mem_be     out  4   byte enables, bit i = mem_wdata[8i+7:8i]
//  mem_ack    in   1   memory accepted write (sampled on clk)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; hold regs and wait counter 0. Reset mid-REQ drops
//   mem_req immediately (async), no st_done/st_err is generated for the lost store.
//  Accept = st_valid & ~flush & (state==IDLE). st_stall = st_valid & ~flush & (state!=IDLE),
//   combinational. flush has no effect on a store already in REQ (write is posted).
//  Lane rules, off = st_addr[1:0]: wdata = st_data << (8*off) (SB/SH/SW alike);
//   be: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111.
//  Legality: SH needs off[0]==0; SW needs off==0; st_op 11 illegal. Illegal op wins over
//   misaligned when both apply.
//  FSM:
//   IDLE: on accept & legal -> capture mem_addr/mem_wdata/mem_be, counter=0, go REQ.
//         on accept & illegal -> latch err_code/err_addr, go ERR. Else stay.
//   REQ : mem_req=1, mem_addr/wdata/be stable. mem_ack=1 -> IDLE, st_done=1 next cycle.
//         else counter++; if MAX_WAIT!=0 and counter reaches MAX_WAIT-1 -> IDLE with
//         st_err=1, err_code=10, err_addr=captured address. mem_ack in same cycle as
//         timeout: ack wins.
//   ERR : st_err=1 for exactly this cycle, mem_req=0, -> IDLE.
//  Latency: accept at edge N -> mem_req high from N+1; ack sampled at edge M -> mem_req
//   low and st_done high for cycle after M. Minimum store: 2 cycles busy.
//  A new st_valid in the st_done cycle is accepted (state is IDLE).
//  err_code/err_addr hold their last value between errors; mem_* hold captured values in
//   IDLE, only mem_req qualifies them.
//  Counter width $clog2(MAX_WAIT+1), saturates; never wraps.
// TESTING
//  1 SW addr 0x100 data 0xDEADBEEF, ack 3 cycles after req -> mem_addr 0x100, be 1111,
//    wdata DEADBEEF, mem_req 3 cycles, st_done pulse 1 cycle after ack.
//  2 SB addr 0x203 data 0x000000A5 -> mem_addr 0x200, be 1000, wdata A5000000; SH addr
//    0x302 data 0x1234 -> be 1100, wdata 12340000.
//  3 SH addr 0x301 -> no mem_req, st_err pulse, err_code 01, err_addr 0x301; st_op 11 at
//    0x300 -> err_code 11.
//  4 Second SW while first in REQ -> st_stall high until first completes, second accepted
//    in st_done cycle; flush with st_valid in IDLE -> nothing captured.
//  5 MAX_WAIT=15, no ack -> mem_req high exactly 15 cycles, st_err, err_code 10; ack in
//    the 15th cycle -> st_done, no error.
//  6 rst_n low mid-REQ -> mem_req 0 same cycle, outputs 0; after release, IDLE accepts.

Source files
------------

// File: rtl/store_unit_ctrl.sv
// Store-path sequencer: aligns store data onto byte lanes, checks legality and
// drives a one-entry posted req/ack write to data memory.
module store_unit_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        flush,
  output logic        st_stall,
  output logic        st_done,
  output logic        st_err,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);
  localparam logic          TIMEOUT_EN = (MAX_WAIT != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [1:0] OP_SB = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SW = 2'b10;
  localparam logic [1:0] OP_IL = 2'b11;

  localparam logic [1:0] EC_MISALIGN = 2'b01;
  localparam logic [1:0] EC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EC_ILLEGAL  = 2'b11;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   addr_hold, addr_hold_nxt;
  logic          st_done_nxt, st_err_nxt, mem_req_nxt;
  logic [1:0]    err_code_nxt;
  logic [31:0]   err_addr_nxt, mem_addr_nxt, mem_wdata_nxt;
  logic [3:0]    mem_be_nxt;

  logic          accept, illegal_op, misaligned, timeout_hit;
  logic [1:0]    off;
  logic [31:0]   lane_wdata;
  logic [3:0]    lane_be;

  // Lane alignment, byte enables and legality of the incoming store
  always_comb begin
    off        = st_addr[1:0];
    lane_wdata = st_data << {off, 3'b000};
    illegal_op = (st_op == OP_IL);
    misaligned = 1'b0;
    lane_be    = 4'b0000;
    case (st_op)
      OP_SB: lane_be = 4'b0001 << off;
      OP_SH: begin
        lane_be    = 4'b0011 << off;
        misaligned = off[0];
      end
      OP_SW: begin
        lane_be    = 4'b1111;
        misaligned = (off != 2'b00);
      end
      default: lane_be = 4'b0000;
    endcase
  end

  assign accept      = st_valid & ~flush & (state == S_IDLE);
  assign st_stall    = st_valid & ~flush & (state != S_IDLE);
  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LIMIT);

  // Next-state and next-value logic for every registered output
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    addr_hold_nxt = addr_hold;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_be_nxt    = mem_be;
    err_code_nxt  = err_code;
    err_addr_nxt  = err_addr;
    st_done_nxt   = 1'b0;
    st_err_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (illegal_op) begin
            err_code_nxt = EC_ILLEGAL;
            err_addr_nxt = st_addr;
            st_err_nxt   = 1'b1;
            state_nxt    = S_ERR;
          end else if (misaligned) begin
            err_code_nxt = EC_MISALIGN;
            err_addr_nxt = st_addr;
            st_err_nxt   = 1'b1;
            state_nxt    = S_ERR;
          end else begin
            addr_hold_nxt = st_addr;
            mem_addr_nxt  = {st_addr[31:2], 2'b00};
            mem_wdata_nxt = lane_wdata;
            mem_be_nxt    = lane_be;
            cnt_nxt       = '0;
            state_nxt     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          st_done_nxt = 1'b1;
          state_nxt   = S_IDLE;
        end else if (timeout_hit) begin
          st_err_nxt   = 1'b1;
          err_code_nxt = EC_TIMEOUT;
          err_addr_nxt = addr_hold;
          state_nxt    = S_IDLE;
        end else if (cnt != {CW{1'b1}}) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    mem_req_nxt = (state_nxt == S_REQ);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_hold <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      err_code  <= '0;
      err_addr  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr_hold <= addr_hold_nxt;
      mem_req   <= mem_req_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_be    <= mem_be_nxt;
      st_done   <= st_done_nxt;
      st_err    <= st_err_nxt;
      err_code  <= err_code_nxt;
      err_addr  <= err_addr_nxt;
    end
  end

endmodule

// File: tb/tb_store_unit_ctrl.sv
// Self-checking bench for store_unit_ctrl: directed vector table, hand-written
// corner sequences and randomized stores checked against a behavioural model.
module tb_store_unit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, flush, mem_ack;
  logic [1:0]  st_op;
  logic [31:0] st_addr, st_data;
  logic        st_stall, st_done, st_err, mem_req;
  logic [1:0]  err_code;
  logic [31:0] err_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  logic [1:0]  last_code;
  logic [31:0] last_eaddr;

  store_unit_ctrl #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .flush(flush), .st_stall(st_stall),
    .st_done(st_done), .st_err(st_err), .err_code(err_code), .err_addr(err_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // One store: inputs, ack latency (0 = never) and expected results
  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_n;
    logic [1:0]  code;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          reqc;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: size/offset arithmetic straight from the lane rules
  function automatic vec_t model(input logic [1:0] op, input logic [31:0] addr,
                                 input logic [31:0] data, input int ack_n);
    vec_t v;
    int size, off, b;
    longint unsigned p;
    off  = int'(addr % 4);
    size = (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
    v.op = op; v.addr = addr; v.data = data; v.ack_n = ack_n;
    p = longint'(data) * (64'd1 << (8 * off));
    b = ((1 << size) - 1) * (1 << off);
    v.maddr = addr - 32'(off);
    v.wdata = p[31:0];
    v.be    = b[3:0];
    if (op == 2'd3)               v.code = 2'b11;
    else if ((addr % size) != 0)  v.code = 2'b01;
    else if (ack_n < 1 || ack_n > 15) v.code = 2'b10;
    else                          v.code = 2'b00;
    if (v.code == 2'b11 || v.code == 2'b01) v.reqc = 0;
    else v.reqc = (v.code == 2'b10) ? 15 : ack_n;
    return v;
  endfunction

  // Present one store from IDLE and follow it to completion
  task automatic run_store(input vec_t r);
    int cycles;
    st_op = r.op; st_addr = r.addr; st_data = r.data; st_valid = 1'b1;
    chk("stall_idle", 32'(st_stall), 32'd0);
    step();
    st_valid = 1'b0;
    if (r.code == 2'b01 || r.code == 2'b11) begin
      chk("rej_req", 32'(mem_req), 32'd0);
      chk("rej_err", 32'(st_err), 32'd1);
      chk("rej_code", 32'(err_code), 32'(r.code));
      chk("rej_eaddr", err_addr, r.addr);
      last_code = r.code; last_eaddr = r.addr;
      step();
      chk("rej_pulse", 32'(st_err), 32'd0);
      chk("rej_nodone", 32'(st_done), 32'd0);
    end else begin
      chk("req_on", 32'(mem_req), 32'd1);
      chk("maddr", mem_addr, r.maddr);
      chk("be", 32'(mem_be), 32'(r.be));
      chk("wdata", mem_wdata, r.wdata);
      cycles = 0;
      while (mem_req && cycles < 40) begin
        cycles++;
        mem_ack = (cycles == r.ack_n);
        step();
        mem_ack = 1'b0;
      end
      chk("req_cycles", 32'(cycles), 32'(r.reqc));
      if (r.code == 2'b10) begin
        chk("to_err", 32'(st_err), 32'd1);
        chk("to_code", 32'(err_code), 32'(2'b10));
        chk("to_eaddr", err_addr, r.addr);
        chk("to_nodone", 32'(st_done), 32'd0);
        last_code = 2'b10; last_eaddr = r.addr;
      end else begin
        chk("done", 32'(st_done), 32'd1);
        chk("done_noerr", 32'(st_err), 32'd0);
        chk("code_hold", 32'(err_code), 32'(last_code));
        chk("eaddr_hold", err_addr, last_eaddr);
      end
      step();
      chk("pulse_end", 32'({st_done, st_err}), 32'd0);
    end
  endtask

  initial begin
    vec_t r;
    tbl[0]  = '{2'd2, 32'h100, 32'hDEADBEEF, 3,  2'b00, 32'h100, 4'hF, 32'hDEADBEEF, 3};
    tbl[1]  = '{2'd0, 32'h203, 32'h000000A5, 1,  2'b00, 32'h200, 4'h8, 32'hA5000000, 1};
    tbl[2]  = '{2'd1, 32'h302, 32'h00001234, 2,  2'b00, 32'h300, 4'hC, 32'h12340000, 2};
    tbl[3]  = '{2'd1, 32'h301, 32'h00001234, 1,  2'b01, 32'h0,   4'h0, 32'h0,        0};
    tbl[4]  = '{2'd3, 32'h300, 32'h00000055, 1,  2'b11, 32'h0,   4'h0, 32'h0,        0};
    tbl[5]  = '{2'd2, 32'h102, 32'h11223344, 1,  2'b01, 32'h0,   4'h0, 32'h0,        0};
    tbl[6]  = '{2'd3, 32'h301, 32'h00000066, 1,  2'b11, 32'h0,   4'h0, 32'h0,        0};
    tbl[7]  = '{2'd0, 32'h001, 32'hFFFFFF77, 1,  2'b00, 32'h000, 4'h2, 32'hFFFF7700, 1};
    tbl[8]  = '{2'd2, 32'h040, 32'hCAFEF00D, 0,  2'b10, 32'h040, 4'hF, 32'hCAFEF00D, 15};
    tbl[9]  = '{2'd2, 32'h044, 32'h01020304, 15, 2'b00, 32'h044, 4'hF, 32'h01020304, 15};
    tbl[10] = '{2'd1, 32'h010, 32'h0000ABCD, 1,  2'b00, 32'h010, 4'h3, 32'h0000ABCD, 1};

    rst_n = 1'b0; st_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    st_op = 2'd0; st_addr = '0; st_data = '0;
    last_code = 2'b00; last_eaddr = '0;
    #1;
    chk("rst_outputs", {mem_req, st_done, st_err, err_code, mem_be, 23'd0}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_eaddr", err_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) run_store(tbl[i]);

    // Second store stalls while the first is pending, then enters in the done cycle
    st_op = 2'd2; st_addr = 32'h500; st_data = 32'h0A0B0C0D; st_valid = 1'b1;
    step();
    st_addr = 32'h600; st_data = 32'h55667788;
    chk("stall_busy1", 32'(st_stall), 32'd1);
    step();
    chk("stall_busy2", 32'(st_stall), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("done_cycle", 32'(st_done), 32'd1);
    chk("stall_released", 32'(st_stall), 32'd0);
    step();
    st_valid = 1'b0;
    chk("second_req", 32'(mem_req), 32'd1);
    chk("second_addr", mem_addr, 32'h600);
    chk("second_wdata", mem_wdata, 32'h55667788);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("second_done", 32'(st_done), 32'd1);
    step();

    // Flush squashes a store in IDLE; nothing is captured
    st_op = 2'd0; st_addr = 32'h777; st_data = 32'hFF; st_valid = 1'b1; flush = 1'b1;
    chk("flush_nostall", 32'(st_stall), 32'd0);
    step();
    st_valid = 1'b0; flush = 1'b0;
    chk("flush_noreq", 32'(mem_req), 32'd0);
    chk("flush_maddr", mem_addr, 32'h600);
    step();
    chk("flush_noerr", 32'({st_done, st_err}), 32'd0);

    // Asynchronous reset in the middle of a request
    st_op = 2'd2; st_addr = 32'h800; st_data = 32'h12345678; st_valid = 1'b1;
    step();
    st_valid = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_maddr", mem_addr, 32'd0);
    chk("rst_mid_flags", 32'({st_done, st_err, err_code}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_code = 2'b00; last_eaddr = '0;
    step();
    chk("post_rst_quiet", 32'({st_done, st_err, mem_req}), 32'd0);
    run_store(tbl[0]);

    // Randomized stores against the behavioural model
    for (int i = 0; i < 60; i++) begin
      int n;
      logic [31:0] a;
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 17)) : int'($urandom_range(1, 4));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r = model(2'($urandom_range(0, 3)), a, $urandom, n);
      run_store(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
